// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: one instruction at a time through fetch/decode/execute/mem/writeback.
// Optional build macro MC_ILLEGAL_TRAP_EN: illegal encodings trap into a sticky HALT state.
module mc_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       alu_srcb,
  output logic [1:0] npc_sel,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [3:0] state,
  output logic       illegal,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXE_R    = 4'd2,
    S_EXE_I    = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB       = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  state_t state_q;
  state_t next_state;

  logic is_special;
  logic op_addu, op_subu, op_jr, op_nop;
  logic op_ori, op_lui, op_lw, op_sw, op_beq, op_j, op_jal;

  // Instruction decode from the IR fields
  always_comb begin
    is_special = (opcode == 6'b000000);
    op_addu    = is_special && (funct == 6'b100001);
    op_subu    = is_special && (funct == 6'b100011);
    op_jr      = is_special && (funct == 6'b001000);
    op_nop     = is_special && (funct == 6'b000000);
    op_ori     = (opcode == 6'b001101);
    op_lui     = (opcode == 6'b001111);
    op_lw      = (opcode == 6'b100011);
    op_sw      = (opcode == 6'b101011);
    op_beq     = (opcode == 6'b000100);
    op_j       = (opcode == 6'b000010);
    op_jal     = (opcode == 6'b000011);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= next_state;
    end
  end

  assign state = state_q;

  // Next-state and control outputs
  always_comb begin
    next_state = state_q;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    ext_op     = 2'b00;
    alu_op     = 3'b000;
    alu_srcb   = 1'b0;
    npc_sel    = 2'b00;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    illegal    = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      next_state = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_wr      = 1'b1;
          pc_wr      = 1'b1;
          next_state = S_DECODE;
        end
        S_DECODE: begin
          if (op_addu || op_subu) begin
            next_state = S_EXE_R;
          end else if (op_ori || op_lui) begin
            next_state = S_EXE_I;
          end else if (op_lw || op_sw) begin
            next_state = S_MEM_ADDR;
          end else if (op_beq) begin
            next_state = S_BRANCH;
          end else if (op_j || op_jal || op_jr) begin
            next_state = S_JUMP;
          end else if (op_nop) begin
            next_state = S_FETCH;
          end else begin
            illegal = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
            next_state = S_HALT;
`else
            next_state = S_FETCH;
`endif
          end
        end
        S_EXE_R: begin
          alu_op     = op_subu ? 3'b001 : 3'b000;
          next_state = S_WB;
        end
        S_EXE_I: begin
          alu_srcb   = 1'b1;
          alu_op     = 3'b010;
          ext_op     = op_lui ? 2'b10 : 2'b00;
          next_state = S_WB;
        end
        S_MEM_ADDR: begin
          alu_srcb   = 1'b1;
          ext_op     = 2'b01;
          next_state = op_sw ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          ext_op     = 2'b01;
          next_state = S_WB;
        end
        S_MEM_WR: begin
          mem_wr     = 1'b1;
          ext_op     = 2'b01;
          next_state = S_FETCH;
        end
        S_WB: begin
          reg_wr = 1'b1;
          // ext_op stays at the value the execute state used for this instruction
          if (is_special) begin
            reg_dst = 2'b01;
          end else if (op_lw) begin
            wd_sel = 2'b01;
            ext_op = 2'b01;
          end else if (op_lui) begin
            ext_op = 2'b10;
          end else begin
            ext_op = 2'b00;
          end
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_op     = 3'b001;
          ext_op     = 2'b01;
          npc_sel    = 2'b01;
          pc_wr      = zero;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          pc_wr = 1'b1;
          if (op_jr) begin
            npc_sel = 2'b11;
          end else begin
            npc_sel = 2'b10;
          end
          if (op_jal) begin
            reg_wr  = 1'b1;
            reg_dst = 2'b10;
            wd_sel  = 2'b10;
          end else begin
            reg_wr  = 1'b0;
          end
          next_state = S_FETCH;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        S_HALT: begin
          halted     = 1'b1;
          next_state = S_HALT;
        end
`endif
        default: begin
          next_state = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: expected per-cycle control vectors are queued by the
// stimulus and popped by a negedge monitor. Honours MC_ILLEGAL_TRAP_EN for the illegal case.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_srcb, illegal, halted;
  logic [1:0] ext_op, npc_sel, reg_dst, wd_sel;
  logic [2:0] alu_op;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;
  logic [21:0] vec_q[$];
  string       name_q[$];

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr),
    .ext_op(ext_op), .alu_op(alu_op), .alu_srcb(alu_srcb), .npc_sel(npc_sel),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .state(state), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  // Field order: state, pc_wr, ir_wr, reg_wr, mem_wr, ext_op, alu_op, alu_srcb, npc_sel, reg_dst, wd_sel, illegal, halted
  function automatic logic [21:0] mk(input logic [3:0] st, input logic pc, input logic ir,
                                     input logic rw, input logic mw, input logic [1:0] ext,
                                     input logic [2:0] alu, input logic srcb, input logic [1:0] npc,
                                     input logic [1:0] rdst, input logic [1:0] wd,
                                     input logic ill, input logic hlt);
    return {st, pc, ir, rw, mw, ext, alu, srcb, npc, rdst, wd, ill, hlt};
  endfunction

  wire [21:0] actual = {state, pc_wr, ir_wr, reg_wr, mem_wr, ext_op, alu_op, alu_srcb,
                        npc_sel, reg_dst, wd_sel, illegal, halted};

  // Monitor: one expected vector per clock cycle
  always @(negedge clk) begin
    if (vec_q.size() > 0) begin
      logic [21:0] e;
      string nm;
      e  = vec_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      if (actual !== e) begin
        fails++;
        $display("FAIL %s: got %b required %b", nm, actual, e);
      end
    end
  end

  task automatic ex(input string nm, input logic [21:0] v);
    name_q.push_back(nm);
    vec_q.push_back(v);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input string nm);
    opcode = op;
    funct  = fn;
    zero   = z;
    ex({nm, "_fetch"},  mk(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex({nm, "_decode"}, mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
  endtask

  task automatic reset_pulse(input string nm);
    ex(nm, 22'd0);
    reset = 1'b1;
    #1;
    tests++;
    if (state !== 4'd0 || reg_wr !== 1'b0 || ir_wr !== 1'b0 || pc_wr !== 1'b0) begin
      fails++;
      $display("FAIL %s_async: got state=%0d reg_wr=%b ir_wr=%b pc_wr=%b required 0,0,0,0",
               nm, state, reg_wr, ir_wr, pc_wr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'd0;
    funct  = 6'd0;
    zero   = 1'b0;
    ex("reset_state", 22'd0);
    cycles(2);
    reset = 1'b0;

    issue(6'b000000, 6'b100001, 1'b0, "addu");
    ex("addu_exe", mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("addu_wb",  mk(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0));
    cycles(4);

    issue(6'b000000, 6'b100011, 1'b0, "subu");
    ex("subu_exe", mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("subu_wb",  mk(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0));
    cycles(4);

    issue(6'b001101, 6'b000000, 1'b0, "ori");
    ex("ori_exe", mk(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("ori_wb",  mk(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    cycles(4);

    issue(6'b001111, 6'b100001, 1'b0, "lui");
    ex("lui_exe", mk(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b010, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("lui_wb",  mk(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    cycles(4);

    issue(6'b100011, 6'b000000, 1'b0, "lw");
    ex("lw_addr", mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("lw_rd",   mk(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("lw_wb",   mk(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0));
    cycles(5);

    issue(6'b101011, 6'b000000, 1'b0, "sw");
    ex("sw_addr", mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("sw_wr",   mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    cycles(4);

    issue(6'b000100, 6'b000000, 1'b1, "beq_taken");
    ex("beq_taken_br", mk(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0));
    cycles(3);

    issue(6'b000100, 6'b000000, 1'b0, "beq_not");
    ex("beq_not_br", mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0));
    cycles(3);

    issue(6'b000010, 6'b000000, 1'b0, "j");
    ex("j_jump", mk(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0));
    cycles(3);

    issue(6'b000011, 6'b000000, 1'b0, "jal");
    ex("jal_jump", mk(4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0));
    cycles(3);

    issue(6'b000000, 6'b001000, 1'b0, "jr");
    ex("jr_jump", mk(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0));
    cycles(3);

    issue(6'b000000, 6'b000000, 1'b0, "nop");
    cycles(2);

    // Reset lands while lw is in MEM_RD; its WB must never happen
    issue(6'b100011, 6'b000000, 1'b0, "lw_rst");
    ex("lw_rst_addr", mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    cycles(3);
    reset_pulse("lw_midreset");

    issue(6'b000000, 6'b100001, 1'b0, "addu2");
    ex("addu2_exe", mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("addu2_wb",  mk(4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0));
    cycles(4);

    opcode = 6'b111111;
    funct  = 6'b000000;
    ex("ill_fetch",  mk(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    ex("ill_decode", mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 22; i++) begin
      ex("ill_halt", mk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    end
    cycles(24);
    reset_pulse("halt_reset");
`else
    cycles(2);
`endif

    issue(6'b000000, 6'b000000, 1'b0, "nop_after_ill");
    cycles(2);

    for (int k = 0; k < 100 && vec_q.size() > 0; k++) begin
      @(posedge clk);
    end
    tests++;
    if (vec_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending required 0", vec_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
